clk_period_meter: RTL

//  Receive side of the divided-clock path: measures a slow clock-like signal (e.g. a divided clock)
//  in cycles of the fast system clock. Synchronises sig_in, detects rising edges and counts cycles

---
 rtl/clk_period_meter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/clk_period_meter.sv
// ---------------------------------------------------------------------------
// clk_period_meter
//
// Measures a slow, clock-like signal (typically a divided clock) in cycles of
// the fast system clock. sig_in is synchronised, rising edges are detected,
// and the number of clk cycles between consecutive rising edges is delivered
// on a valid/ready output. A sticky timeout flags loss of toggling. A sticky
// overrun flags a result that was replaced before it was consumed.
//
// Optional feature macro: DUTY_MEAS_EN
//   defined   : meas_high reports the clk cycles sig_in was high in the period
//   undefined : high-time logic is not built and meas_high is tied to 0
//
// Parameters
//   CNT_W        width of the period/high counters and outputs
//   SYNC_STAGES  flops in the sig_in synchroniser (>= 2)
//   TIMEOUT      cycles without a rising edge before timeout (2 .. 2^CNT_W-1)
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous, active-high reset
//   sig_in       asynchronous signal to be measured
//   meas_valid   a measurement is available
//   meas_ready   consumer accepts; transfer on meas_valid && meas_ready
//   meas_period  clk cycles between consecutive sig_in rising edges
//   meas_high    clk cycles sig_in was high within that period
//   timeout      sticky: no rising edge for TIMEOUT cycles
//   overrun      sticky: a result was overwritten before being accepted
// ---------------------------------------------------------------------------
module clk_period_meter #(
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic {IDLE, MEAS} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sync_d_p1;
    logic [CNT_W-1:0]       cnt;
    logic                   res_ovw;

    logic                   sig_s;
    logic                   rise;
    logic                   new_res;
    logic                   accept;
    logic                   to_hit;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE_C;
    endfunction

    // ---- stage p0/p1: synchroniser output and its one-cycle delay ----------
    assign sig_s   = sync_p0[SYNC_STAGES-1];
    assign rise    = sig_s & ~sync_d_p1;
    assign new_res = (state == MEAS) && rise;
    assign accept  = meas_valid && meas_ready;
    // A rise in the same cycle takes priority over the timeout.
    assign to_hit  = (state == MEAS) && !rise && (cnt == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0     <= '0;
            sync_d_p1   <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            meas_valid  <= 1'b0;
            meas_period <= '0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
            res_ovw     <= 1'b0;
        end else begin
            sync_p0   <= {sync_p0[SYNC_STAGES-2:0], sig_in};
            sync_d_p1 <= sig_s;

            // The first edge after reset or timeout only arms the counter:
            // the period before it is partial.
            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= MEAS;
                        cnt     <= ONE_C;
                        timeout <= 1'b0;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        cnt <= ONE_C;
                    end else if (to_hit) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: state <= IDLE;
            endcase

            // res_ovw remembers whether the result on display replaced an
            // unconsumed one; only accepting a clean result clears overrun.
            if (new_res) begin
                meas_valid  <= 1'b1;
                meas_period <= cnt;
                if (meas_valid && !meas_ready) begin
                    overrun <= 1'b1;
                    res_ovw <= 1'b1;
                end else begin
                    res_ovw <= 1'b0;
                end
            end else if (accept) begin
                meas_valid <= 1'b0;
                if (!res_ovw) begin
                    overrun <= 1'b0;
                end
            end
        end
    end

`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] high_cnt;

    // ---- stage p1: high-time accumulation alongside cnt --------------------
    // The rise cycle is itself a high cycle of the new period, so the count
    // restarts at 1 rather than 0; a 50% duty period of N reports N/2.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_cnt  <= '0;
            meas_high <= '0;
        end else begin
            if (rise) begin
                high_cnt <= ONE_C;
            end else if ((state == MEAS) && !to_hit) begin
                if (sig_s) begin
                    high_cnt <= sat_inc(high_cnt);
                end
            end else begin
                high_cnt <= '0;
            end
            if (new_res) begin
                meas_high <= high_cnt;
            end
        end
    end
`else
    assign meas_high = '0;
`endif

endmodule
